ddr3_wb_traffic_gen: RTL and testbench

DDR3_WB_TRAFFIC_GEN -- requirements
Module: ddr3_wb_traffic_gen

---
 rtl/ddr3_wb_traffic_gen.sv | 112 +++++++++++
 tb/tb_ddr3_wb_traffic_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_wb_traffic_gen.sv
// ddr3_wb_traffic_gen: pipelined Wishbone master that writes a pattern to 0..LAST_ADDR, reads it back and counts mismatches.
// Define TRAFFIC_GEN_LFSR_EN to replace the address-XOR-SEED pattern with per-lane Galois LFSRs.
module ddr3_wb_traffic_gen #(
  parameter int          WB_ADDR_BITS = 24,
  parameter int          WB_DATA_BITS = 128,
  parameter int          LAST_ADDR    = 1023,
  parameter logic [31:0] SEED         = 32'hA5A5_0000
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [WB_ADDR_BITS-1:0]   o_wb_addr,
  output logic [WB_DATA_BITS-1:0]   o_wb_data,
  output logic [WB_DATA_BITS/8-1:0] o_wb_sel,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err,
  input  logic [WB_DATA_BITS-1:0]   i_wb_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic [15:0]               o_err_count,
  output logic [WB_ADDR_BITS-1:0]   o_fail_addr
);
  localparam int OW    = $clog2(LAST_ADDR + 2);
  localparam int LANES = WB_DATA_BITS / 32;
  typedef enum logic [2:0] {IDLE, WRITE, WR_DRAIN, GAP, READ, RD_DRAIN, DONE} state_t;
  state_t                  state_q, state_d;
  logic [1:0]              sync_q;
  logic [WB_ADDR_BITS-1:0] addr_q, resp_q, fail_q;
  logic [OW-1:0]           out_q;
  logic [15:0]             err_q;
  logic [WB_DATA_BITS-1:0] wr_pat, exp_w;
  logic                    accept, resp, last, start, rd_phase, bad;
  assign o_wb_stb    = state_q == WRITE || state_q == READ;
  assign o_wb_cyc    = o_wb_stb || state_q == WR_DRAIN || state_q == RD_DRAIN;
  assign o_wb_we     = state_q == WRITE;
  assign o_wb_sel    = '1;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = o_wb_we ? wr_pat : '0;
  assign o_busy      = !(state_q == IDLE || state_q == DONE);
  assign o_done      = state_q == DONE;
  assign o_pass      = o_done && err_q == 16'd0;
  assign o_err_count = err_q;
  assign o_fail_addr = fail_q;
  assign accept   = o_wb_stb && !i_wb_stall;
  assign last     = addr_q == WB_ADDR_BITS'(LAST_ADDR);
  assign start    = i_start && sync_q[1] && !o_busy;
  // responses only count while the cycle is open, so stale acks after a reset are dropped
  assign resp     = o_wb_cyc && (i_wb_ack || i_wb_err);
  assign rd_phase = state_q == READ || state_q == RD_DRAIN;
  assign bad      = resp && (i_wb_err || (rd_phase && i_wb_data != exp_w));
`ifdef TRAFFIC_GEN_LFSR_EN
  logic [WB_DATA_BITS-1:0] wr_lfsr_q, rd_lfsr_q, seed_v;
  function automatic logic [WB_DATA_BITS-1:0] step(input logic [WB_DATA_BITS-1:0] v);
    step = v;
    for (int i = 0; i < LANES; i++)
      step[i*32 +: 32] = {1'b0, v[i*32+1 +: 31]} ^ (v[i*32] ? 32'h8020_0003 : 32'h0);
  endfunction
  for (genvar g = 0; g < LANES; g++) begin : g_seed
    assign seed_v[g*32 +: 32] = SEED ^ 32'(g);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_lfsr_q <= '0;
      rd_lfsr_q <= '0;
    end else begin
      wr_lfsr_q <= start ? seed_v : (accept && o_wb_we) ? step(wr_lfsr_q) : wr_lfsr_q;
      rd_lfsr_q <= start ? seed_v : (resp && rd_phase) ? step(rd_lfsr_q) : rd_lfsr_q;
    end
  end
  assign wr_pat = wr_lfsr_q;
  assign exp_w  = rd_lfsr_q;
`else
  assign wr_pat = {LANES{32'(addr_q) ^ SEED}};
  assign exp_w  = {LANES{32'(resp_q) ^ SEED}};
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? WRITE : state_q;
      WRITE:      state_d = (accept && last) ? WR_DRAIN : WRITE;
      WR_DRAIN:   state_d = out_q == '0 ? GAP : WR_DRAIN;
      GAP:        state_d = READ;
      READ:       state_d = (accept && last) ? RD_DRAIN : READ;
      RD_DRAIN:   state_d = out_q == '0 ? DONE : RD_DRAIN;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      addr_q  <= '0;
      resp_q  <= '0;
      out_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], 1'b1};
      addr_q  <= (start || state_q == GAP) ? '0 : accept ? (last ? '0 : addr_q + 1'b1) : addr_q;
      resp_q  <= (start || state_q == GAP) ? '0 : resp ? resp_q + 1'b1 : resp_q;
      out_q   <= out_q + OW'(accept) - OW'(resp);
      err_q   <= start ? '0 : (bad && ~&err_q) ? err_q + 16'd1 : err_q;
      fail_q  <= start ? '0 : (bad && err_q == 16'd0) ? resp_q : fail_q;
    end
  end
endmodule

// File: tb/tb_ddr3_wb_traffic_gen.sv
// tb_ddr3_wb_traffic_gen: directed scenarios against a pipelined memory model with configurable latency, stalls and faults.
module tb_ddr3_wb_traffic_gen;
  localparam int          LA   = 15;
  localparam logic [31:0] SEED = 32'hA5A5_0000;
  logic         clk = 0, rst_n = 0, start = 0;
  logic         cyc, stb, we, stall = 0, ack = 0, err = 0, busy, done, pass;
  logic [23:0]  addr, fail_addr;
  logic [127:0] wdata, rdata = '0;
  logic [15:0]  sel, err_cnt;
  logic         cyc0, stb0, we0, ack0 = 0, busy0, done0, pass0;
  logic [23:0]  addr0, fail0;
  logic [127:0] wdata0, rdata0 = '0;
  logic [15:0]  sel0, err0;
  int n_cmp = 0, n_bad = 0;

  ddr3_wb_traffic_gen #(.LAST_ADDR(LA), .SEED(SEED)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(addr), .o_wb_data(wdata), .o_wb_sel(sel),
    .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err), .i_wb_data(rdata),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_count(err_cnt), .o_fail_addr(fail_addr));

  ddr3_wb_traffic_gen #(.LAST_ADDR(0), .SEED(SEED)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_wb_cyc(cyc0), .o_wb_stb(stb0), .o_wb_we(we0), .o_wb_addr(addr0), .o_wb_data(wdata0), .o_wb_sel(sel0),
    .i_wb_stall(1'b0), .i_wb_ack(ack0), .i_wb_err(1'b0), .i_wb_data(rdata0),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_count(err0), .o_fail_addr(fail0));

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input int a);
    logic [31:0] w;
    w = 32'(a) ^ SEED;
    return {4{w}};
  endfunction

  typedef struct {logic w; logic [3:0] a; logic e; int due;} rsp_t;
  rsp_t q[$];
  rsp_t r;
  logic [127:0] mem [0:15];
  logic [127:0] held, first_wd = '0, d0 = '0;
  logic clr = 0, stall_en = 0, acc0 = 0;
  int lat = 1, err_wr_addr = -1, flip_a = -1, flip_b = -1;
  int cyc_n = 0, wr_count = 0, rd_count = 0, wr_next = 0, rd_next = 0, rd_out = 0;
  int order_bad = 0, data_bad = 0, stall_cnt = 0, stall_bad = 0, w0 = 0, r0 = 0;

  // Memory model: decides stall and presents due responses at the negedge, then records what the next posedge accepts.
  always @(negedge clk) begin
    cyc_n++;
    if (clr) begin
      q.delete();
      wr_count = 0; rd_count = 0; wr_next = 0; rd_next = 0; rd_out = 0;
      order_bad = 0; data_bad = 0; stall_cnt = 0; stall_bad = 0; w0 = 0; r0 = 0;
    end
    stall = 0;
    if (stall_en && stb && we && addr == 24'd3 && stall_cnt < 5) begin
      stall = 1;
      if (stall_cnt == 0) held = wdata;
      else if (wdata !== held || addr !== 24'd3) stall_bad++;
      stall_cnt++;
    end
    ack = 0; err = 0; rdata = '0;
    if (q.size() > 0 && q[0].due <= cyc_n) begin
      r = q.pop_front();
      err = r.e;
      ack = !r.e;
      if (!r.w) begin
        rdata = mem[r.a] ^ ((int'(r.a) == flip_a || int'(r.a) == flip_b) ? 128'h80 : 128'h0);
        rd_out--;
      end
    end
    if (stb && !stall) begin
      q.push_back('{we, addr[3:0], we && int'(addr) == err_wr_addr, cyc_n + lat});
      if (we) begin
        if (int'(addr) != wr_next) order_bad++;
`ifndef TRAFFIC_GEN_LFSR_EN
        if (wdata !== pat(wr_next)) data_bad++;
`endif
        if (addr == 24'd0) first_wd = wdata;
        mem[addr[3:0]] = wdata;
        wr_next++; wr_count++;
      end else begin
        if (int'(addr) != rd_next) order_bad++;
        rd_next++; rd_count++; rd_out++;
      end
    end
    ack0 = acc0;
    rdata0 = d0;
    acc0 = stb0;
    if (stb0) begin
      if (we0) begin w0++; d0 = wdata0; end
      else r0++;
    end
  end

  task automatic model_clear();
    clr = 1;
    @(negedge clk);
    #1 clr = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s_timeout done=%0b required 1", nm, done); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({cyc, stb, we, busy, done, pass} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl got %b required 000000", {cyc, stb, we, busy, done, pass}); end
    n_cmp++; if (addr !== 24'd0 || wdata !== 128'd0) begin n_bad++; $display("FAIL reset_addr_data got %h/%h required 0/0", addr, wdata); end
    n_cmp++; if (err_cnt !== 16'd0 || fail_addr !== 24'd0) begin n_bad++; $display("FAIL reset_status got %h/%h required 0/0", err_cnt, fail_addr); end
    n_cmp++; if (sel !== 16'hFFFF) begin n_bad++; $display("FAIL sel got %h required ffff", sel); end
    rst_n = 1;
    start = 1;
    @(negedge clk) start = 0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_sync busy=%0b required 0", busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clean_pass();
    model_clear();
    pulse_start();
    wait_done("clean");
    n_cmp++; if (pass !== 1'b1 || err_cnt !== 16'd0) begin n_bad++; $display("FAIL clean_pass pass=%0b err=%0d required 1/0", pass, err_cnt); end
    n_cmp++; if (wr_count != 16 || rd_count != 16) begin n_bad++; $display("FAIL clean_counts wr=%0d rd=%0d required 16/16", wr_count, rd_count); end
    n_cmp++; if (order_bad != 0 || data_bad != 0) begin n_bad++; $display("FAIL clean_order_data order=%0d data=%0d required 0/0", order_bad, data_bad); end
    n_cmp++; if (cyc !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL clean_idle_bus cyc=%0b busy=%0b required 0/0", cyc, busy); end
    n_cmp++; if (w0 != 1 || r0 != 1 || done0 !== 1'b1 || pass0 !== 1'b1) begin n_bad++; $display("FAIL last0 wr=%0d rd=%0d done=%0b pass=%0b required 1/1/1/1", w0, r0, done0, pass0); end
  endtask

  task automatic test_stall_hold();
    model_clear();
    stall_en = 1;
    pulse_start();
    wait_done("stall");
    stall_en = 0;
    n_cmp++; if (stall_cnt != 5 || stall_bad != 0) begin n_bad++; $display("FAIL stall_hold cycles=%0d unstable=%0d required 5/0", stall_cnt, stall_bad); end
    n_cmp++; if (wr_count != 16 || order_bad != 0 || data_bad != 0) begin n_bad++; $display("FAIL stall_seq wr=%0d order=%0d data=%0d required 16/0/0", wr_count, order_bad, data_bad); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL stall_pass pass=%0b required 1", pass); end
  endtask

  task automatic test_corruption();
    model_clear();
    flip_a = 4; flip_b = 9;
    pulse_start();
    wait_done("corrupt");
    flip_a = -1; flip_b = -1;
    n_cmp++; if (err_cnt !== 16'd2) begin n_bad++; $display("FAIL corrupt_count got %0d required 2", err_cnt); end
    n_cmp++; if (fail_addr !== 24'd4) begin n_bad++; $display("FAIL corrupt_fail_addr got %0d required 4", fail_addr); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL corrupt_pass got %0b required 0", pass); end
  endtask

  task automatic test_bus_error();
    model_clear();
    err_wr_addr = 2;
    pulse_start();
    wait_done("buserr");
    err_wr_addr = -1;
    n_cmp++; if (err_cnt !== 16'd1 || pass !== 1'b0) begin n_bad++; $display("FAIL buserr err=%0d pass=%0b required 1/0", err_cnt, pass); end
    n_cmp++; if (rd_count != 16) begin n_bad++; $display("FAIL buserr_reads got %0d required 16", rd_count); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    model_clear();
    lat = 4;
    pulse_start();
    @(negedge clk); #1;
    while (!(stb && !we && rd_out >= 3) && n < 500) begin @(negedge clk); #1; n++; end
    n_cmp++; if (rd_out < 3) begin n_bad++; $display("FAIL areset_setup outstanding=%0d required >=3", rd_out); end
    #1 rst_n = 0;
    #1;
    n_cmp++; if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL areset_immediate cyc=%0b stb=%0b busy=%0b required 0/0/0", cyc, stb, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    n_cmp++; if (err_cnt !== 16'd0 || busy !== 1'b0 || cyc !== 1'b0) begin n_bad++; $display("FAIL areset_stale_acks err=%0d busy=%0b cyc=%0b required 0/0/0", err_cnt, busy, cyc); end
    lat = 1;
    model_clear();
    pulse_start();
    wait_done("areset");
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL areset_rerun pass=%0b required 1", pass); end
  endtask

  task automatic test_restart();
    model_clear();
    pulse_start();
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || we !== 1'b1) begin n_bad++; $display("FAIL restart_in_write busy=%0b we=%0b required 1/1", busy, we); end
    pulse_start();
    wait_done("ignored_start");
    n_cmp++; if (wr_count != 16 || order_bad != 0 || pass !== 1'b1) begin n_bad++; $display("FAIL ignored_start wr=%0d order=%0d pass=%0b required 16/0/1", wr_count, order_bad, pass); end
    n_cmp++; if (first_wd[31:0] !== SEED) begin n_bad++; $display("FAIL first_word got %h required %h", first_wd[31:0], SEED); end
    model_clear();
    flip_a = 6;
    pulse_start();
    wait_done("pre_restart");
    flip_a = -1;
    n_cmp++; if (err_cnt !== 16'd1 || fail_addr !== 24'd6) begin n_bad++; $display("FAIL pre_restart err=%0d fail=%0d required 1/6", err_cnt, fail_addr); end
    pulse_start();
    n_cmp++; if (err_cnt !== 16'd0 || fail_addr !== 24'd0 || pass !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL restart_clear err=%0d fail=%0d pass=%0b busy=%0b required 0/0/0/1", err_cnt, fail_addr, pass, busy); end
    wait_done("restart");
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL restart_pass got %0b required 1", pass); end
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_stall_hold();
    test_corruption();
    test_bus_error();
    test_async_reset();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
